// File: rtl/operand_stack.sv
// operand_stack: synchronous LIFO operand stack for the stack CPU core.
// Latency: push updates top/count one edge later; pop presents dout one edge later.
// Backpressure: none. Illegal push/pop is dropped and raises a sticky overflow/underflow flag.
//
// Ports:
//   clk, reset          - single clock; synchronous active-high reset
//   push, pop, din      - operation strobes (level-sampled each edge) and push operand
//   err_clr             - clears both sticky error flags (a same-cycle set wins)
//   dout                - value removed by the last successful pop (or replace-top)
//   top                 - registered copy of the current top entry, 0 when empty
//   count, full, empty  - occupancy and its decodes
//   overflow, underflow - sticky error flags
module operand_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   input  logic             err_clr,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] top,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [CNT_W-1:0] cnt_m1;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    below_idx;

   logic do_push;      // plain push into free slot
   logic do_pop;       // plain pop from non-empty stack
   logic do_repl;      // push+pop on non-empty stack: overwrite top in place
   logic do_pe;        // push+pop on empty stack: behaves as a push, dout cleared
   logic ovf_set;
   logic unf_set;
   logic mem_we;
   logic [AW-1:0] mem_wa;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   assign cnt_m1    = count - CNT_W'(1);
   assign wr_idx    = count[AW-1:0];
   assign top_idx   = cnt_m1[AW-1:0];
   assign below_idx = top_idx - AW'(1);

   assign do_push = push & ~pop & ~full;
   assign do_pop  = pop & ~push & ~empty;
   assign do_repl = push & pop & ~empty;
   assign do_pe   = push & pop & empty;
   assign ovf_set = push & ~pop & full;
   assign unf_set = pop & ~push & empty;

   // Any operation in the reset cycle is discarded, including the array write.
   assign mem_we = ~reset & (do_push | do_pe | do_repl);
   assign mem_wa = do_repl ? top_idx : wr_idx;

   // Storage has no reset: entries at or above count are never read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         dout      <= '0;
         top       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_push || do_pe) begin
            count <= count + CNT_W'(1);
            top   <= din;
         end
         if (do_pe) begin
            dout <= '0;
         end
         if (do_pop) begin
            dout  <= top;
            count <= cnt_m1;
            // Popping the last entry leaves the top at 0 instead of a stale read.
            top   <= (count == CNT_W'(1)) ? '0 : mem[below_idx];
         end
         if (do_repl) begin
            dout <= top;
            top  <= din;
         end
         // Set has priority over clear; each flag is independent.
         overflow  <= ovf_set | (overflow & ~err_clr);
         underflow <= unf_set | (underflow & ~err_clr);
      end
   end

endmodule

// File: doc/operand_stack.md
# operand_stack

Synchronous LIFO operand stack that sits directly downstream of the stack CPU core. It accepts push and pop strobes plus an 8-bit operand and returns the popped value one cycle later. It also exports the current top-of-stack, occupancy, and full/empty status. Illegal operations raise sticky error flags for the CPU's error indicator.

## Interface
- WIDTH, 8, data width of each stack entry
- DEPTH, 16, number of entries (2..256)
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter

- Clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; sampled on the Clock rising edge
- push  in  1  write din onto stack this cycle
- pop  in  1  remove top entry this cycle
- din  in  WIDTH  operand to push
- err_clr  in  1  clears overflow/underflow flags
- dout  out  WIDTH  registered value removed by the last successful pop
- top  out  WIDTH  registered copy of current top entry; 0 when empty
- count  out  CNT_W  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array plus stack pointer sp = count. Entry sp-1 is the top.
- Each cycle with a strobe high is one operation. Strobes are level-sampled per edge, with no edge detection.
- Decode on each edge, evaluated in priority order:
  - reset: count=0, dout=0, top=0, overflow=0, underflow=0. Array contents are don't-care and are never read while empty.
  - push only, not full: mem[count]<=din, count+1, top<=din.
  - push only, full: no state change, overflow<=1.
  - pop only, not empty: dout<=mem[count-1], count-1. top<=mem[count-2], or 0 if count becomes 0.
  - pop only, empty: no state change, dout holds, underflow<=1.
  - push and pop, not empty: replace-top. dout<=old top, mem[count-1]<=din, top<=din, count unchanged.
  - push and pop, empty: treated as push only, with no underflow. Then dout<=0, and din is stored with count=1.
  - neither: hold all state.
- err_clr clears both sticky flags.
  - If err_clr and an erroring op occur in the same cycle, the set wins.
  - Flags are independent: an overflow does not clear underflow.
- full and empty are combinational decodes of the count register, so they are glitch-free relative to Clock.
- No wrap-around: count saturates at DEPTH and 0 through the rejection rules above, and the pointer never wraps.
- Arithmetic: count uses CNT_W bits, so DEPTH itself is representable. Data is passed unmodified and carries no sign interpretation.

## Timing
- Push: din is captured at edge k. top and count reflect it immediately after edge k, so the latency is 1.
- Pop: pop is sampled at edge k. dout is valid after edge k and holds until the next successful pop or reset. This lets the CPU assert pop in one state and read dout in the next state.
- Back-to-back pops on consecutive cycles are legal. Each yields the next-lower entry on dout in successive cycles.
- Push at edge k followed by pop at edge k+1 returns the pushed value on dout after edge k+1.
- Error flags rise after the offending edge and stay high until err_clr or reset.
- Reset mid-sequence: any push or pop in the same cycle as reset is discarded. After that edge the stack is empty.
- The block has no combinational path from inputs to outputs.

## Test plan
- Reset, then idle 3 cycles -> count=0, empty=1, full=0, top=0, dout=0, overflow=0, underflow=0.
- Push 23, push 5, pop, pop on consecutive cycles -> top goes 23, 5, 23, 0. dout=5 after the third edge and 23 after the fourth. Ends with empty=1.
- Push values 1..16 (DEPTH=16), then push 99 -> full=1 after the 16th push. The 17th push sets overflow=1, count stays 16, top=16. Popping 16 times then returns 16..1 in order.
- Pop on empty -> underflow=1, dout unchanged, count=0. err_clr alone for one cycle -> underflow=0. err_clr in the same cycle as a second empty pop -> underflow stays 1.
- Push 10, then push and pop together with din=40 -> dout=10, top=40, count=1. Push and pop together while empty with din=7 -> count=1, top=7, underflow=0.
- Push 3 values, then assert reset in the same cycle as a push of 200 -> after the edge count=0, top=0, and 200 is not stored. A following pop sets underflow.
